// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite initiator: one command in, one SINGLE transfer out on a 64-bit bus.
// Optional macro AHB_MST_RDATA_ALIGN_EN right-justifies read data by address and size.
module ahb_lite_master #(
    parameter logic [3:0] HPROT_VAL      = 4'b0011,
    parameter int         TIMEOUT_CYCLES = 256
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_size,
    input  logic [63:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_error,
    output logic        rsp_timeout,
    output logic [63:0] rsp_rdata,
    output logic        busy,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [63:0] HWDATA,
    input  logic [63:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);
    typedef enum logic [2:0] {S_IDLE, S_CHK, S_ADDR, S_DATA, S_ERR2} state_t;

    localparam logic [1:0]  TR_IDLE   = 2'b00;
    localparam logic [1:0]  TR_NONSEQ = 2'b10;
    localparam bit          WDOG_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [31:0] WDOG_LIM  = 32'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_error_q, rsp_error_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic [63:0] rsp_rdata_q, rsp_rdata_d;
    logic [31:0] haddr_q, haddr_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [63:0] hwdata_q, hwdata_d;
    logic [63:0] wdata_q, wdata_d;
    logic [15:0] wdog_q, wdog_d;

    logic        misaligned;
    logic [15:0] wdog_inc;
    logic        wdog_fire;
    logic        bus_state;
    logic [63:0] rd_fmt;

    always_comb begin
        case (hsize_q)
            3'd0:    misaligned = 1'b0;
            3'd1:    misaligned = haddr_q[0];
            3'd2:    misaligned = |haddr_q[1:0];
            3'd3:    misaligned = |haddr_q[2:0];
            default: misaligned = 1'b1;
        endcase
    end

`ifdef AHB_MST_RDATA_ALIGN_EN
    logic [63:0] rd_shift;
    always_comb begin
        rd_shift = HRDATA >> {haddr_q[2:0], 3'b000};
        case (hsize_q)
            3'd0:    rd_fmt = {56'd0, rd_shift[7:0]};
            3'd1:    rd_fmt = {48'd0, rd_shift[15:0]};
            3'd2:    rd_fmt = {32'd0, rd_shift[31:0]};
            default: rd_fmt = rd_shift;
        endcase
    end
`else
    assign rd_fmt = HRDATA;
`endif

    assign wdog_inc  = (wdog_q == 16'hFFFF) ? wdog_q : wdog_q + 16'd1;
    assign wdog_fire = WDOG_EN && ({16'd0, wdog_inc} >= WDOG_LIM);
    assign bus_state = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_ERR2);

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = 1'b0;
        rsp_error_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        rsp_rdata_d   = 64'd0;
        haddr_d       = haddr_q;
        htrans_d      = htrans_q;
        hwrite_d      = hwrite_q;
        hsize_d       = hsize_q;
        hwdata_d      = hwdata_q;
        wdata_d       = wdata_q;
        wdog_d        = 16'd0;

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    haddr_d     = cmd_addr;
                    hwrite_d    = cmd_write;
                    hsize_d     = cmd_size;
                    wdata_d     = cmd_wdata;
                    state_d     = S_CHK;
                end
            end
            S_CHK: begin
                if (misaligned) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    htrans_d = TR_NONSEQ;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    htrans_d = TR_IDLE;
                    hwdata_d = wdata_q;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                if (HREADY) begin
                    // A one-cycle ERROR (HREADY=1 with HRESP=1) is still reported as an error.
                    rsp_valid_d = 1'b1;
                    rsp_error_d = HRESP;
                    rsp_rdata_d = (HRESP || hwrite_q) ? 64'd0 : rd_fmt;
                    state_d     = S_IDLE;
                end else if (HRESP) begin
                    state_d = S_ERR2;
                end
            end
            S_ERR2: begin
                if (HREADY) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Watchdog only runs while the bus holds us in the same state.
        if (bus_state && !HREADY && (state_d == state_q)) begin
            wdog_d = wdog_inc;
            if (wdog_fire) begin
                wdog_d        = 16'd0;
                htrans_d      = TR_IDLE;
                rsp_valid_d   = 1'b1;
                rsp_error_d   = 1'b1;
                rsp_timeout_d = 1'b1;
                rsp_rdata_d   = 64'd0;
                state_d       = S_IDLE;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= 64'd0;
            haddr_q       <= 32'd0;
            htrans_q      <= TR_IDLE;
            hwrite_q      <= 1'b0;
            hsize_q       <= 3'd0;
            hwdata_q      <= 64'd0;
            wdata_q       <= 64'd0;
            wdog_q        <= 16'd0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
            haddr_q       <= haddr_d;
            htrans_q      <= htrans_d;
            hwrite_q      <= hwrite_d;
            hsize_q       <= hsize_d;
            hwdata_q      <= hwdata_d;
            wdata_q       <= wdata_d;
            wdog_q        <= wdog_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign busy        = (state_q != S_IDLE);
    assign HADDR       = haddr_q;
    assign HTRANS      = htrans_q;
    assign HWRITE      = hwrite_q;
    assign HSIZE       = hsize_q;
    assign HBURST      = 3'b000;
    assign HPROT       = HPROT_VAL;
    assign HWDATA      = hwdata_q;
endmodule

// File: tb/tb_ahb_lite_master.sv
// Self-checking bench for ahb_lite_master: acts as a cycle-scripted AHB slave and predicts
// each transaction's timing and response from the command, wait states and slave reply.
module tb_ahb_lite_master;
    localparam int TMO = 8;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'd0;
    logic [2:0]  cmd_size = 3'd0;
    logic [63:0] cmd_wdata = 64'd0;
    logic        rsp_valid, rsp_error, rsp_timeout, busy;
    logic [63:0] rsp_rdata;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [63:0] HWDATA;
    logic [63:0] HRDATA = 64'd0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 HCLK = ~HCLK;

    ahb_lite_master #(.HPROT_VAL(4'b0011), .TIMEOUT_CYCLES(TMO)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .rsp_rdata(rsp_rdata), .busy(busy),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Expected read data as seen by the requester.
    function automatic logic [63:0] exp_read(input logic [63:0] raw, input logic [31:0] addr,
                                             input logic [2:0] size);
        logic [63:0] v;
        v = raw;
`ifdef AHB_MST_RDATA_ALIGN_EN
        v = raw >> (8 * int'(addr[2:0]));
        if (size < 3'd3) v = v & ((64'd1 << (8 * (1 << size))) - 64'd1);
`else
        if (addr[0] === 1'bx || size[0] === 1'bx) v = raw;
`endif
        return v;
    endfunction

    // err: 0 = OKAY, 1 = two-cycle ERROR, 2 = single-cycle ERROR (HREADY=1 with HRESP=1)
    task automatic run_cmd(input string tag, input bit wr, input logic [31:0] addr,
                           input logic [2:0] size, input logic [63:0] wdata,
                           input int aw, input int dw, input int err, input logic [63:0] rdata);
        bit misal, tmo, in_addr;
        int lat, d0, waitc;
        logic [63:0] erd;
        misal = (size > 3'd3) || ((addr % (32'd1 << size)) != 32'd0);
        tmo   = !misal && (aw >= TMO);
        if (misal)    lat = 2;
        else if (tmo) lat = 2 + TMO;
        else          lat = 4 + aw + dw + ((err == 1) ? 1 : 0);
        d0  = 3 + aw;
        erd = (misal || tmo || err != 0 || wr) ? 64'd0 : exp_read(rdata, addr, size);

        waitc = 0;
        @(negedge HCLK);
        while (cmd_ready !== 1'b1 && waitc < 20) begin
            @(negedge HCLK);
            waitc++;
        end
        chk({tag, "_ready"}, {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_wdata = wdata;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = rdata;
        @(posedge HCLK);
        #1 cmd_valid = 1'b0;

        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge HCLK);
            in_addr = !misal && (c >= 2) && (c <= (tmo ? 1 + TMO : 2 + aw));
            chk({tag, "_htrans"}, 64'(HTRANS), in_addr ? 64'd2 : 64'd0);
            if (in_addr) begin
                chk({tag, "_haddr"}, 64'(HADDR), 64'(addr));
                chk({tag, "_hwrite"}, 64'(HWRITE), 64'(wr));
                chk({tag, "_hsize"}, 64'(HSIZE), 64'(size));
            end
            if (wr && !misal && !tmo && c >= d0 && c <= d0 + dw)
                chk({tag, "_hwdata"}, HWDATA, wdata);
            chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(c == lat));
            chk({tag, "_rsp_error"}, 64'(rsp_error), 64'(c == lat && (misal || tmo || err != 0)));
            chk({tag, "_rsp_timeout"}, 64'(rsp_timeout), 64'(c == lat && tmo));
            chk({tag, "_rsp_rdata"}, rsp_rdata, (c == lat) ? erd : 64'd0);
            chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(c > lat));
            chk({tag, "_busy"}, 64'(busy), 64'(c < lat));
            HREADY = 1'b1; HRESP = 1'b0;
            if (!misal) begin
                if (c >= 2 && c < 2 + aw)                       HREADY = 1'b0;
                else if (c >= d0 && c < d0 + dw)                HREADY = 1'b0;
                else if (c == d0 + dw && err == 1)              begin HREADY = 1'b0; HRESP = 1'b1; end
                else if (c == d0 + dw + 1 && err == 1)          HRESP = 1'b1;
                else if (c == d0 + dw && err == 2)              HRESP = 1'b1;
            end
        end
        $display("txn %s wr=%0d addr=%h size=%0d aw=%0d dw=%0d err=%0d lat=%0d", tag, wr, addr,
                 size, aw, dw, err, lat);
    endtask

    initial begin
        logic [31:0] ra;
        logic [2:0]  rs;
        int          rsel, raw_, rdw, rerr;

        repeat (2) @(negedge HCLK);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_htrans", 64'(HTRANS), 64'd0);
        chk("rst_haddr", 64'(HADDR), 64'd0);
        chk("rst_hwdata", HWDATA, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("hburst", 64'(HBURST), 64'd0);
        chk("hprot", 64'(HPROT), 64'h3);
        HRESETn = 1'b1;
        #1 chk("rel_cmd_ready_low", 64'(cmd_ready), 64'd0);
        @(negedge HCLK);
        chk("rel_cmd_ready_high", 64'(cmd_ready), 64'd1);

        run_cmd("rd_dword",   1'b0, 32'h8,  3'd3, 64'd0, 0, 0, 0, 64'h1122334455667788);
        run_cmd("wr_word_ws", 1'b1, 32'h4,  3'd2, 64'hDEADBEEF_00000000, 0, 3, 0, 64'h55);
        run_cmd("rd_error",   1'b0, 32'h10, 3'd3, 64'd0, 0, 0, 1, 64'hA5A5A5A5A5A5A5A5);
        run_cmd("half_misal", 1'b0, 32'h3,  3'd1, 64'd0, 0, 0, 0, 64'h1234);
        run_cmd("timeout",    1'b0, 32'h20, 3'd3, 64'd0, 20, 0, 0, 64'h99);
        run_cmd("wd_edge",    1'b0, 32'h6,  3'd1, 64'd0, TMO - 1, TMO - 1, 0, 64'hCAFEF00D12345678);
        run_cmd("bad_size",   1'b1, 32'h0,  3'd5, 64'h1, 0, 0, 0, 64'h0);
        run_cmd("err_1cyc",   1'b1, 32'h40, 3'd0, 64'hFF, 1, 1, 2, 64'h77);
        run_cmd("rd_byte",    1'b0, 32'h5,  3'd0, 64'd0, 1, 2, 0, 64'h0011223344556677);

        // Asynchronous reset in the data phase of a read.
        @(negedge HCLK);
        while (cmd_ready !== 1'b1) @(negedge HCLK);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h18; cmd_size = 3'd3;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 64'h0BADF00D0BADF00D;
        @(posedge HCLK);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge HCLK);
        chk("mid_busy", 64'(busy), 64'd1);
        chk("mid_htrans_data", 64'(HTRANS), 64'd0);
        HREADY = 1'b0;
        @(negedge HCLK);
        #2 HRESETn = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_haddr", 64'(HADDR), 64'd0);
        chk("mid_rst_hwrite_hsize", {60'd0, HWRITE, HSIZE}, 64'd0);
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
        HREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            chk("mid_rst_no_rsp", 64'(rsp_valid), 64'd0);
        end
        HRESETn = 1'b1;
        run_cmd("post_rst", 1'b0, 32'h18, 3'd3, 64'd0, 0, 0, 0, 64'h0123456789ABCDEF);

        for (int n = 0; n < 40; n++) begin
            rsel = $urandom_range(0, 9);
            rs   = (rsel == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            ra   = $urandom;
            if ($urandom_range(0, 3) != 0 && rs <= 3'd3) ra = ra & ~((32'd1 << rs) - 32'd1);
            raw_ = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO, TMO + 2) : $urandom_range(0, 3);
            rdw  = $urandom_range(0, 3);
            rsel = $urandom_range(0, 5);
            rerr = (rsel == 4) ? 1 : (rsel == 5) ? 2 : 0;
            run_cmd("rand", 1'($urandom_range(0, 1)), ra, rs, {$urandom, $urandom}, raw_, rdw, rerr,
                    {$urandom, $urandom});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end
endmodule
